// File: rtl/uart_tx.sv
// LSB-first UART transmitter: start, data, optional parity and stop bits, one bit per CLK.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic [CW-1:0]         bit_cnt;
    logic                  last_bit;
    logic                  accept;
    logic                  parity_bit;
    logic                  tx_next;
    logic                  busy_next;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_done;
`endif

    assign accept     = (state == IDLE) && DATA_VALID;
    assign last_bit   = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign parity_bit = (^data_reg) ^ par_typ_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (DATA_VALID) state_next = START;
            START:  state_next = DATA;
            DATA: begin
                if (last_bit) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: state_next = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:   state_next = stop_done ? IDLE : STOP;
`else
            STOP:   state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed one state ahead and registered, so the line lags the FSM by a cycle.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
        unique case (state)
            IDLE:   busy_next = DATA_VALID;
            START:  tx_next = 1'b0;
            DATA:   tx_next = data_reg[bit_cnt];
            PARITY: tx_next = parity_bit;
            STOP:   tx_next = 1'b1;
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            TX_OUT      <= 1'b1;
            Busy        <= 1'b0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            TX_OUT <= tx_next;
            Busy   <= busy_next;
            if (accept) begin
                data_reg    <= P_DATA;
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
                bit_cnt     <= '0;
            end else if (state == DATA && !last_bit) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_done <= 1'b0;
        end else begin
            stop_done <= (state == STOP) && !stop_done;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed scoreboard bench for uart_tx: expected line/busy pairs are queued
// per frame and compared one cycle at a time.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
        if (pen) exp_q.push_back({(^d) ^ ptyp, 1'b1});
        exp_q.push_back(2'b11);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(2'b11);
`endif
        exp_q.push_back(2'b10);
    endtask

    task automatic drain(input string tag, input int glitch_at, input int rst_at);
        int idx = 0;
        logic [1:0] e;
        while (exp_q.size() > 0) begin
            @(posedge CLK);
            #1;
            DATA_VALID = 1'b0;
            P_DATA     = ~P_DATA;
            if (RST) begin
                RST = 1'b0;
                exp_q.delete();
                exp_q.push_back(2'b10);
            end
            e = exp_q.pop_front();
            check($sformatf("%s_tx[%0d]", tag, idx), TX_OUT, e[1]);
            check($sformatf("%s_busy[%0d]", tag, idx), Busy, e[0]);
            idx++;
            if (idx == glitch_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'h55;
            end
            if (idx == rst_at) RST = 1'b1;
        end
    endtask

    initial begin
        RST        = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            check("reset_tx", TX_OUT, 1'b1);
            check("reset_busy", Busy, 1'b0);
        end
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_tx", TX_OUT, 1'b1);
        check("idle_busy", Busy, 1'b0);

        send(8'h2E, 1'b1, 1'b0); drain("2e_even", -1, -1);
        send(8'h2E, 1'b1, 1'b1); drain("2e_odd", -1, -1);
        send(8'h2E, 1'b0, 1'b0); drain("2e_nopar", -1, -1);
        send(8'hAE, 1'b1, 1'b0); drain("ae_even", -1, -1);
        send(8'hAE, 1'b1, 1'b1); drain("ae_odd", -1, -1);
        send(8'hAE, 1'b0, 1'b1); drain("ae_nopar", -1, -1);
        send(8'h2E, 1'b1, 1'b0); drain("glitch", 5, -1);
        send(8'hC3, 1'b0, 1'b0); drain("glitch_late", 10, -1);
        send(8'hA5, 1'b1, 1'b1); drain("rst_mid", -1, 6);
        send(8'h3C, 1'b0, 1'b0); drain("after_rst", -1, -1);
        send(8'h81, 1'b1, 1'b0); drain("edge_81", -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
